// File: rtl/checker_pkg.sv
// Shared types and constants for the program result checker.
package checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned FAIL_W = 3;
    localparam int unsigned CYC_W  = 16;

    localparam logic [FAIL_W-1:0] FAIL_NONE    = 3'd0;
    localparam logic [FAIL_W-1:0] FAIL_TIMEOUT = 3'd1;
    localparam logic [FAIL_W-1:0] FAIL_PC      = 3'd2;
    localparam logic [FAIL_W-1:0] FAIL_UNSEEN  = 3'd3;
    localparam logic [FAIL_W-1:0] FAIL_VALUE   = 3'd4;

endpackage

// File: rtl/chk_slot.sv
// One expected-result slot: config storage, address match, write capture, seen flag.
module chk_slot #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_en,
    input  logic              clr,
    input  logic              cap_en,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              en,
    output logic              seen,
    output logic              match_c
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] cap_q;
    logic              hit_c;

    assign hit_c   = cap_en && mem_we && en && (addr_q == mem_addr);
    assign match_c = (cap_q == exp_q);

    // Slot configuration, only written while the checker is idle or done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            addr_q <= '0;
            exp_q  <= '0;
        end else if (cfg_we) begin
            en     <= cfg_en;
            addr_q <= cfg_addr;
            exp_q  <= cfg_data;
        end
    end

    // Capture the most recent CPU write to the slot address during a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            seen  <= 1'b0;
        end else if (clr) begin
            cap_q <= '0;
            seen  <= 1'b0;
        end else if (hit_c) begin
            cap_q <= mem_wdata;
            seen  <= 1'b1;
        end
    end

endmodule

// File: rtl/prog_result_checker.sv
// Watches a CPU run, captures writes to configured addresses and grades the result at halt.
module prog_result_checker
    import checker_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PC_W    = 9,
    parameter int unsigned N_CHK   = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_we,
    input  logic [((N_CHK > 1) ? $clog2(N_CHK) : 1)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]                       cfg_addr,
    input  logic [DATA_W-1:0]                       cfg_data,
    input  logic                                    cfg_en,
    input  logic [PC_W-1:0]                         exp_pc,
    input  logic                                    start,
    input  logic                                    halt,
    input  logic [PC_W-1:0]                         pc,
    input  logic                                    mem_we,
    input  logic [ADDR_W-1:0]                       mem_addr,
    input  logic [DATA_W-1:0]                       mem_wdata,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    pass,
    output logic [FAIL_W-1:0]                       fail_code,
    output logic [((N_CHK > 1) ? $clog2(N_CHK) : 1)-1:0] fail_idx,
    output logic [CYC_W-1:0]                        cycles
);

    localparam int unsigned IDX_W  = (N_CHK > 1) ? $clog2(N_CHK) : 1;
    localparam int unsigned STEP_W = $clog2(N_CHK + 1);

    state_t             state_q;
    state_t             state_d;
    logic [PC_W-1:0]    exp_pc_q;
    logic [PC_W-1:0]    pc_q;
    logic [STEP_W-1:0]  chk_step;
    logic [N_CHK-1:0]   slot_we;
    logic [N_CHK-1:0]   slot_en;
    logic [N_CHK-1:0]   slot_seen;
    logic [N_CHK-1:0]   slot_match;
    logic               idle_c;
    logic               run_start_c;
    logic               cap_en_c;
    logic [CYC_W-1:0]   cycles_inc_c;
    logic [IDX_W-1:0]   slot_sel_c;
    logic               fail_set_c;
    logic [FAIL_W-1:0]  fail_code_c;
    logic [IDX_W-1:0]   fail_idx_c;

    assign idle_c       = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign run_start_c  = start && idle_c;
    assign cap_en_c     = (state_q == ST_RUN);
    assign cycles_inc_c = (cycles == '1) ? cycles : cycles + CYC_W'(1);
    // Step 0 of CHECK grades the PC; steps 1..N_CHK grade slots 0..N_CHK-1.
    assign slot_sel_c   = IDX_W'(chk_step - STEP_W'(1));

    for (genvar i = 0; i < N_CHK; i++) begin : g_slot
        assign slot_we[i] = cfg_we && idle_c && (cfg_idx == IDX_W'(i));

        chk_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .cfg_we    (slot_we[i]),
            .cfg_addr  (cfg_addr),
            .cfg_data  (cfg_data),
            .cfg_en    (cfg_en),
            .clr       (run_start_c),
            .cap_en    (cap_en_c),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .en        (slot_en[i]),
            .seen      (slot_seen[i]),
            .match_c   (slot_match[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle failure detection.
    always_comb begin
        state_d     = state_q;
        fail_set_c  = 1'b0;
        fail_code_c = FAIL_NONE;
        fail_idx_c  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_CHECK;
                end else if (32'(cycles_inc_c) >= TIMEOUT) begin
                    state_d     = ST_DONE;
                    fail_set_c  = 1'b1;
                    fail_code_c = FAIL_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (chk_step == '0) begin
                    if (pc_q != exp_pc_q) begin
                        fail_set_c  = 1'b1;
                        fail_code_c = FAIL_PC;
                    end
                end else if (slot_en[slot_sel_c] && !slot_seen[slot_sel_c]) begin
                    fail_set_c  = 1'b1;
                    fail_code_c = FAIL_UNSEEN;
                    fail_idx_c  = slot_sel_c;
                end else if (slot_en[slot_sel_c] && !slot_match[slot_sel_c]) begin
                    fail_set_c  = 1'b1;
                    fail_code_c = FAIL_VALUE;
                    fail_idx_c  = slot_sel_c;
                end
                if (chk_step == STEP_W'(N_CHK)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run bookkeeping, first-failure capture and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FAIL_NONE;
            fail_idx  <= '0;
            cycles    <= '0;
            chk_step  <= '0;
            exp_pc_q  <= '0;
            pc_q      <= '0;
        end else begin
            busy <= (state_d == ST_RUN) || (state_d == ST_CHECK);
            done <= (state_d == ST_DONE);
            if (run_start_c) begin
                pass      <= 1'b0;
                fail_code <= FAIL_NONE;
                fail_idx  <= '0;
                cycles    <= '0;
                chk_step  <= '0;
                exp_pc_q  <= exp_pc;
            end else begin
                if (state_q == ST_RUN) begin
                    cycles   <= cycles_inc_c;
                    chk_step <= '0;
                    if (halt) begin
                        pc_q <= pc;
                    end
                end
                if (state_q == ST_CHECK) begin
                    chk_step <= chk_step + STEP_W'(1);
                end
                if (fail_set_c && (fail_code == FAIL_NONE)) begin
                    fail_code <= fail_code_c;
                    fail_idx  <= fail_idx_c;
                end
                if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
                    pass <= (fail_code == FAIL_NONE) && !fail_set_c;
                end
            end
        end
    end

endmodule
